// File: rtl/screen_refresh_arbiter_pkg.sv
// Purpose : shared state encodings, default screen geometry and address helper.
// Latency : n/a (definitions only).
// Backpressure: n/a.
// Contents: state_e (S_IDLE/S_RUN/S_DRAIN), SCREEN_BASE_DEF, SCREEN_WORDS_DEF,
//           counter widths and the screen address helper.
package screen_refresh_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [14:0] SCREEN_BASE_DEF  = 15'h4000;
  localparam int          SCREEN_WORDS_DEF = 8192;

  // 13 bits covers the largest legal frame (8192 words).
  localparam int CNT_W    = 13;
  // Starvation counter width: MAX_WAIT is bounded to 255.
  localparam int STARVE_W = 8;

  // Screen word address. Legal parameters keep base + index inside 15 bits.
  function automatic logic [14:0] screen_addr(input logic [14:0]      base,
                                              input logic [CNT_W-1:0] idx);
    return base + {2'b00, idx};
  endfunction

endpackage

// File: rtl/screen_refresh_arbiter_starve_timer.sv
// Purpose : saturating count of consecutive cycles the DMA was blocked by the CPU.
// Latency : count updates on the clock edge; o_at_max is a registered-state decode.
// Backpressure: none; i_clr wins over i_inc, counting stops at MAX_WAIT.
// Ports   : clock, reset_n (async active-low), i_inc (blocked cycle),
//           i_clr (grant or no demand), o_at_max (count == MAX_WAIT).
module starve_timer
  import screen_refresh_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [STARVE_W-1:0] LP_MAX = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LP_MAX)) begin
      r_count <= r_count + STARVE_W'(1);
    end
  end

  assign o_at_max = (r_count == LP_MAX);

endmodule

// File: rtl/screen_refresh_arbiter.sv
// Purpose : shares the Hack data-memory port between the CPU and a screen-refresh DMA.
// Latency : grant/mem_*/cpu_* combinational; pix_* registered one edge after a DMA grant.
// Backpressure: DMA fetches only when the pixel register is free (!pix_valid || pix_ready);
//               CPU has priority except for a forced steal after MAX_WAIT blocked cycles.
// Ports   : clock, reset_n | CPU side cpu_req/cpu_address/cpu_in/cpu_load -> cpu_out/cpu_stall
//           | memory side mem_address/mem_in/mem_load <- mem_out
//           | display side frame_start -> pix_data/pix_valid/pix_last (pix_ready),
//             frame_done, frame_overrun.
module screen_refresh_arbiter
  import screen_refresh_arbiter_pkg::*;
#(
  parameter logic [14:0] SCREEN_BASE  = SCREEN_BASE_DEF,
  parameter int          SCREEN_WORDS = SCREEN_WORDS_DEF,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  // CPU side
  input  logic        cpu_req,
  input  logic [14:0] cpu_address,
  input  logic [15:0] cpu_in,
  input  logic        cpu_load,
  output logic [15:0] cpu_out,
  output logic        cpu_stall,
  // Memory side
  output logic [14:0] mem_address,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out,
  // Display side
  input  logic        frame_start,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        frame_done,
  output logic        frame_overrun
);

  // Parameter sanity, caught at elaboration.
  if ((SCREEN_WORDS < 1) || (SCREEN_WORDS > 8192) ||
      ((SCREEN_WORDS & (SCREEN_WORDS - 1)) != 0)) begin : g_bad_words
    $error("SCREEN_WORDS must be a power of two no larger than 8192");
  end
  if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_wait
    $error("MAX_WAIT must be in 1..255");
  end

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(SCREEN_WORDS - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_pix_data;
  logic               r_pix_valid;
  logic               r_pix_last;
  logic               r_frame_done;
  logic               r_frame_overrun;

  logic               w_buf_free;
  logic               w_dma_want;
  logic               w_at_max;
  logic               w_force;
  logic               w_dma_grant;
  logic               w_handshake;
  logic               w_fetch_last;
  logic               w_done_nxt;
  logic               w_overrun_nxt;
  logic               w_starve_inc;
  logic               w_starve_clr;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_buf_free   = !r_pix_valid || pix_ready;
  assign w_dma_want   = (r_state == S_RUN) && w_buf_free;
  assign w_force      = w_dma_want && w_at_max;
  assign w_dma_grant  = w_force || (w_dma_want && !cpu_req);
  assign w_handshake  = r_pix_valid && pix_ready;
  assign w_fetch_last = (r_cnt == LP_LAST);

  // A stall can only come from a forced steal, since an unforced DMA grant
  // requires the CPU to be idle.
  assign cpu_stall = cpu_req && w_dma_grant;
  assign cpu_out   = mem_out;

  always_comb begin
    mem_address = cpu_address;
    mem_in      = cpu_in;
    mem_load    = cpu_load;
    if (w_dma_grant) begin
      // DMA reads only; this also suppresses the CPU write on a stall cycle.
      mem_address = screen_addr(SCREEN_BASE, r_cnt);
      mem_load    = 1'b0;
    end
  end

  // Blocked-cycle counting: only while the DMA actually wants the port and
  // the CPU holds it. Any grant, or losing demand, restarts the count.
  assign w_starve_inc = w_dma_want && cpu_req && !w_force;
  assign w_starve_clr = w_dma_grant || !w_dma_want;

  starve_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_at_max)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_overrun_nxt = frame_start;
        if (w_dma_grant && w_fetch_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No fetches happen here, so the final word leaves by handshake only.
        w_overrun_nxt = frame_start;
        if (w_handshake && r_pix_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Word counter: cleared at frame start, advanced once per fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) && frame_start) begin
      r_cnt <= '0;
    end else if (w_dma_grant) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel output register (single-entry skid: refilled in the same cycle
  // the sink takes the current word, giving one word per cycle).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else if (w_dma_grant) begin
      r_pix_data  <= mem_out;
      r_pix_valid <= 1'b1;
      r_pix_last  <= w_fetch_last;
    end else if (w_handshake) begin
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done    <= 1'b0;
      r_frame_overrun <= 1'b0;
    end else begin
      r_frame_done    <= w_done_nxt;
      r_frame_overrun <= w_overrun_nxt;
    end
  end

  assign pix_data      = r_pix_data;
  assign pix_valid     = r_pix_valid;
  assign pix_last      = r_pix_last;
  assign frame_done    = r_frame_done;
  assign frame_overrun = r_frame_overrun;

endmodule
